// File: rtl/store_capture_if.sv
// Store-bus, arming and drain signals between the core/host side and the
// store_capture block.
interface store_capture_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3
);
    logic                  mem_wrM;
    logic [DATA_WIDTH-1:0] ALU_resultM;
    logic [DATA_WIDTH-1:0] wr_dataM;
    logic                  arm;
    logic [DATA_WIDTH-1:0] exp_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  done;
    logic                  pass;

    modport master (
        output mem_wrM, ALU_resultM, wr_dataM, arm, exp_addr, exp_data, out_ready,
        input  out_valid, out_addr, out_data, count, overflow, done, pass
    );

    modport slave (
        input  mem_wrM, ALU_resultM, wr_dataM, arm, exp_addr, exp_data, out_ready,
        output out_valid, out_addr, out_data, count, overflow, done, pass
    );
endinterface

// File: rtl/store_capture.sv
// Logs core stores into a first-word-fall-through FIFO drained over valid/ready
// and compares them against an armed address/data pair to give a verdict.
module store_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic           clk,
    input  logic           rstn,
    store_capture_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(32'd1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(32'd1);
    localparam logic [DATA_WIDTH-1:0] W_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [EW-1:0]         E_ZERO   = {EW{1'b0}};

    logic [1:0]            state_r,    state_s;
    logic [DATA_WIDTH-1:0] exp_addr_r, exp_addr_s;
    logic [DATA_WIDTH-1:0] exp_data_r, exp_data_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_r,   wr_ptr_s;
    logic [DEPTH_LOG2-1:0] rd_ptr_r,   rd_ptr_s;
    logic [DEPTH_LOG2:0]   count_r,    count_s;
    logic                  overflow_r, overflow_s;
    logic                  done_r,     done_s;
    logic                  pass_r,     pass_s;
    logic                  out_valid_r, out_valid_s;
    logic [EW-1:0]         head_r,     head_s;
    logic [EW-1:0]         mem_r [DEPTH];

    logic          pop_s;
    logic          capture_s;
    logic          full_s;
    logic          push_s;
    logic          drop_s;
    logic          addr_hit_s;
    logic          data_hit_s;
    logic [EW-1:0] entry_s;

    // Per-cycle FIFO and compare qualifiers; arm masks all pushes and drops.
    always_comb begin
        entry_s    = {bus.ALU_resultM, bus.wr_dataM};
        pop_s      = out_valid_r && bus.out_ready;
        capture_s  = bus.mem_wrM && (state_r != ST_IDLE);
        full_s     = (count_r == CNT_FULL);
        push_s     = !bus.arm && capture_s && (!full_s || pop_s);
        drop_s     = !bus.arm && capture_s && full_s && !pop_s;
        addr_hit_s = (bus.ALU_resultM == exp_addr_r);
        data_hit_s = (bus.wr_dataM == exp_data_r);
    end

    // Next-state for the verdict FSM, pointers, occupancy and sticky flags.
    always_comb begin
        state_s    = state_r;
        exp_addr_s = exp_addr_r;
        exp_data_s = exp_data_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        done_s     = done_r;
        pass_s     = pass_r;
        if (bus.arm) begin
            state_s    = ST_ARMED;
            exp_addr_s = bus.exp_addr;
            exp_data_s = bus.exp_data;
            wr_ptr_s   = PTR_ZERO;
            rd_ptr_s   = PTR_ZERO;
            count_s    = CNT_ZERO;
            overflow_s = 1'b0;
            done_s     = 1'b0;
            pass_s     = 1'b0;
        end else begin
            case (state_r)
                ST_ARMED: begin
                    // Dropped stores still reach this compare.
                    if (bus.mem_wrM && addr_hit_s) begin
                        if (data_hit_s) begin
                            state_s = ST_PASS;
                            pass_s  = 1'b1;
                        end else begin
                            state_s = ST_FAIL;
                            pass_s  = 1'b0;
                        end
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    state_s = state_r;
                end
                default: begin
                    state_s = ST_IDLE;
                    done_s  = 1'b0;
                    pass_s  = 1'b0;
                end
            endcase

            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_s = rd_ptr_r;
            end

            if (push_s && !pop_s) begin
                count_s = count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_s = count_r - CNT_ONE;
            end else begin
                count_s = count_r;
            end

            overflow_s = overflow_r | drop_s;
        end
    end

    // Head register lookahead; bypass the incoming entry when it lands on the new head slot.
    always_comb begin
        out_valid_s = (count_s != CNT_ZERO);
        if (count_s == CNT_ZERO) begin
            head_s = E_ZERO;
        end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = entry_s;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (rstn && push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            exp_addr_r  <= W_ZERO;
            exp_data_r  <= W_ZERO;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            out_valid_r <= 1'b0;
            head_r      <= E_ZERO;
        end else begin
            state_r     <= state_s;
            exp_addr_r  <= exp_addr_s;
            exp_data_r  <= exp_data_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            out_valid_r <= out_valid_s;
            head_r      <= head_s;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_addr  = head_r[EW-1:DATA_WIDTH];
    assign bus.out_data  = head_r[DATA_WIDTH-1:0];
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
endmodule

// File: tb/tb_store_capture.sv
// Directed and randomized checks of store_capture against a queue-based
// reference model of its logging, drain and verdict rules.
module tb_store_capture;
    localparam int DW    = 32;
    localparam int DL    = 3;
    localparam int DEPTH = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    store_capture_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) bus ();

    store_capture #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 armed, 2 verdict reached.
    logic [63:0] q[$];
    int          m_mode = 0;
    bit          m_ov   = 1'b0;
    bit          m_done = 1'b0;
    bit          m_pass = 1'b0;
    logic [31:0] m_ea   = 32'd0;
    logic [31:0] m_ed   = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit a, input bit w,
                              input logic [31:0] ad, input logic [31:0] da,
                              input logic [31:0] ea, input logic [31:0] ed, input bit rdy);
        if (!r) begin
            q.delete();
            m_mode = 0; m_ov = 1'b0; m_done = 1'b0; m_pass = 1'b0;
            m_ea = 32'd0; m_ed = 32'd0;
        end else if (a) begin
            q.delete();
            m_mode = 1; m_ov = 1'b0; m_done = 1'b0; m_pass = 1'b0;
            m_ea = ea; m_ed = ed;
        end else begin
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (w && m_mode != 0) begin
                if (q.size() < DEPTH) q.push_back({ad, da});
                else m_ov = 1'b1;
            end
            if (w && m_mode == 1 && ad == m_ea) begin
                m_done = 1'b1;
                m_pass = (da == m_ed);
                m_mode = 2;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] head;
        head = (q.size() != 0) ? q[0] : 64'd0;
        chk("count",     64'(bus.count),     64'(q.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("out_addr",  64'(bus.out_addr),  64'(head[63:32]));
        chk("out_data",  64'(bus.out_data),  64'(head[31:0]));
        chk("overflow",  64'(bus.overflow),  64'(m_ov));
        chk("done",      64'(bus.done),      64'(m_done));
        chk("pass",      64'(bus.pass),      64'(m_pass));
    endtask

    task automatic cycle(input bit r, input bit a, input bit w,
                         input logic [31:0] ad, input logic [31:0] da,
                         input logic [31:0] ea, input logic [31:0] ed, input bit rdy);
        rstn            = r;
        bus.arm         = a;
        bus.mem_wrM     = w;
        bus.ALU_resultM = ad;
        bus.wr_dataM    = da;
        bus.exp_addr    = ea;
        bus.exp_data    = ed;
        bus.out_ready   = rdy;
        model_step(r, a, w, ad, da, ea, ed, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic store(input logic [31:0] ad, input logic [31:0] da, input bit rdy);
        cycle(1'b1, 1'b0, 1'b1, ad, da, 32'd0, 32'd0, rdy);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_arm(input logic [31:0] ea, input logic [31:0] ed);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, ea, ed, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        // Reset, then a passing verdict and ordered drain.
        do_reset();
        chk("rst_count", 64'(bus.count), 64'd0);
        do_arm(32'd100, 32'd25);
        store(32'd96, 32'd7, 1'b0);
        store(32'd100, 32'd25, 1'b0);
        chk("t1_done", 64'(bus.done), 64'd1);
        chk("t1_pass", 64'(bus.pass), 64'd1);
        chk("t1_count", 64'(bus.count), 64'd2);
        chk("t1_h0_addr", 64'(bus.out_addr), 64'd96);
        chk("t1_h0_data", 64'(bus.out_data), 64'd7);
        idle(1'b1);
        chk("t1_h1_addr", 64'(bus.out_addr), 64'd100);
        chk("t1_h1_data", 64'(bus.out_data), 64'd25);
        idle(1'b1);
        chk("t1_empty", 64'(bus.out_valid), 64'd0);

        // Data mismatch at the expected address freezes a fail verdict.
        do_arm(32'd100, 32'd25);
        store(32'd100, 32'd26, 1'b0);
        chk("t2_done", 64'(bus.done), 64'd1);
        chk("t2_pass", 64'(bus.pass), 64'd0);
        store(32'd100, 32'd25, 1'b0);
        chk("t2_pass_frozen", 64'(bus.pass), 64'd0);
        chk("t2_count", 64'(bus.count), 64'd2);

        // Overflow: nine stores into eight slots, ninth dropped.
        do_arm(32'd500, 32'd0);
        for (int i = 1; i <= 9; i++) store(32'd200, 32'(i), 1'b0);
        chk("t3_count", 64'(bus.count), 64'd8);
        chk("t3_overflow", 64'(bus.overflow), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain", 64'(bus.out_data), 64'(i));
            idle(1'b1);
        end
        chk("t3_after_drain", 64'(bus.count), 64'd0);

        // Full FIFO with simultaneous pop and push.
        do_arm(32'd500, 32'd0);
        for (int i = 1; i <= 8; i++) store(32'd300, 32'(i), 1'b0);
        store(32'd300, 32'd99, 1'b1);
        chk("t4_count", 64'(bus.count), 64'd8);
        chk("t4_overflow", 64'(bus.overflow), 64'd0);
        chk("t4_head", 64'(bus.out_data), 64'd2);

        // Idle ignores stores; a store in the arm cycle is ignored too.
        do_reset();
        for (int i = 0; i < 3; i++) store(32'd100, 32'd25, 1'b0);
        chk("t5_idle_count", 64'(bus.count), 64'd0);
        chk("t5_idle_done", 64'(bus.done), 64'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'd100, 32'd25, 32'd100, 32'd25, 1'b0);
        chk("t5_arm_count", 64'(bus.count), 64'd0);
        store(32'd50, 32'd1, 1'b0);
        chk("t5_armed_logs", 64'(bus.count), 64'd1);

        // Reset mid-drain with a verdict present.
        do_arm(32'd100, 32'd25);
        store(32'd100, 32'd25, 1'b0);
        for (int i = 0; i < 4; i++) store(32'd104, 32'(i), 1'b0);
        chk("t6_count", 64'(bus.count), 64'd5);
        chk("t6_done", 64'(bus.done), 64'd1);
        do_reset();
        chk("t6_rst_count", 64'(bus.count), 64'd0);
        chk("t6_rst_done", 64'(bus.done), 64'd0);
        chk("t6_rst_addr", 64'(bus.out_addr), 64'd0);
        store(32'd100, 32'd25, 1'b0);
        chk("t6_post_count", 64'(bus.count), 64'd0);

        // Randomized traffic with phases of slow and fast draining.
        for (int i = 0; i < 3000; i++) begin
            bit r, a, w, rdy;
            r   = ($urandom_range(0, 99) != 0);
            a   = ($urandom_range(0, 29) == 0);
            w   = ($urandom_range(0, 9) < 6);
            rdy = (((i / 200) % 2) == 0) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 3) != 0);
            cycle(r, a, w, 32'd96 + 32'd4 * 32'($urandom_range(0, 3)),
                  32'($urandom_range(0, 3)), 32'd100, 32'($urandom_range(0, 3)), rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/store_capture.md
Name: store_capture

Overview:
- Receiving end of the core's data-memory store bus (mem_wrM / ALU_resultM / wr_dataM) on top_risc.
- Logs every store into a small FIFO and drains it to the host over a valid/ready interface.
- Compares stores against a programmed expected address/data pair to produce a pass/fail verdict.
- Sits beside top_risc in simulation and FPGA bring-up; replaces ad-hoc store checks in benches.

Parameters:
DATA_WIDTH, 32, width of store address and data
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
mem_wrM  in  1  core store strobe; one store per cycle when high
ALU_resultM  in  DATA_WIDTH  store address
wr_dataM  in  DATA_WIDTH  store data
arm  in  1  single-cycle pulse: flush, clear verdict, start capture
exp_addr  in  DATA_WIDTH  expected address; sampled on arm
exp_data  in  DATA_WIDTH  expected data; sampled on arm
out_valid  out  1  FIFO head valid
out_ready  in  1  host accepts head
out_addr  out  DATA_WIDTH  head entry address
out_data  out  DATA_WIDTH  head entry data
count  out  DEPTH_LOG2+1  entries currently held
overflow  out  1  sticky: a store was dropped because the FIFO was full
done  out  1  verdict reached
pass  out  1  verdict is pass (valid only when done=1)

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; FIFO empty; count=0; out_valid=0; out_addr=0; out_data=0; overflow=0; done=0; pass=0; expected registers=0. rstn has priority over every other input, including mid-drain and mid-verdict.
- FSM states: IDLE, ARMED, PASS, FAIL.
  - IDLE: stores are ignored (not logged, not checked).
  - arm=1 in any state: go to ARMED next cycle; latch exp_addr and exp_data; flush FIFO (count=0); clear overflow, done and pass. A store in the same cycle as arm is ignored.
  - ARMED, store with addr==exp_addr and data==exp_data: go to PASS; done=1, pass=1.
  - ARMED, store with addr==exp_addr and data!=exp_data: go to FAIL; done=1, pass=0.
  - ARMED, store to any other address: logged only; stay in ARMED.
  - PASS and FAIL: verdict frozen; stores are still logged; only arm or reset leaves these states.
- Verdict timing: done and pass are registered and go high the cycle after the deciding store edge.
- Capture rule: in any state other than IDLE, a store cycle pushes {ALU_resultM, wr_dataM} if the FIFO is not full.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
  - If the FIFO is full and there is no pop, the store is dropped and overflow goes to 1. Overflow stays 1 until arm or reset.
  - A dropped store is still compared for the verdict.
- FIFO:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers; pointers wrap modulo depth.
  - count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Full when count == 2^DEPTH_LOG2; empty when count == 0.
- Output handshake:
  - out_valid = (count != 0).
  - out_addr and out_data show the head entry whenever out_valid=1 (first-word fall-through). They are 0 when the FIFO is empty.
  - Pop occurs on out_valid && out_ready.
  - out_ready while empty has no effect.
  - Head data is held stable while out_valid=1 and out_ready=0.
- Latency: a store accepted on edge N into an empty FIFO gives out_valid=1 with that entry after edge N.
- Ordering: strict FIFO order; no reordering, no duplication.

Test Plan:
- Reset, arm with exp_addr=100, exp_data=25; stores (96,7), then (100,25) -> done=1, pass=1 one cycle after the second store; count=2; drain returns (96,7) then (100,25).
- Arm (100,25); store (100,26) -> FAIL, done=1, pass=0; a later store (100,25) leaves the verdict at FAIL and raises count to 2.
- Arm; hold out_ready=0; issue 9 consecutive stores with data 1..9 -> count=8, overflow=1; drain returns data 1..8; store 9 is absent.
- Full FIFO with out_ready=1 and a store in the same cycle -> push accepted, count stays 8, overflow stays 0.
- Stores before arm -> count=0, done=0; then arm together with a store in the same cycle -> that store is ignored, state is ARMED, count=0.
- Mid-drain (count=5, done=1), drive rstn=0 for one edge -> all outputs 0, state IDLE; stores after release are ignored until arm.
